rdback_serializer: RTL and testbench

Drains 512-bit read-back lines from the softMC read-back FIFO (`rdback_fifo_empty` / `rdback_fifo_rden` / `rdback_data`) and emits them to the host-side transport as a narrow valid/ready beat stream. It is the stage directly downstream of the memory controller's read path. A two-line ping-pong buffer hides the FIFO's one-cycle read latency, so consecutive lines stream without bubbles. A line counter reports how many lines have been delivered.

---
 rtl/rdback_ser_pkg.sv | 12 +
 rtl/rdback_line_buf.sv | 52 +++++
 rtl/rdback_serializer.sv | 100 ++++++++++
 tb/tb_rdback_serializer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdback_ser_pkg.sv
// Shared constants and types for the read-back line serializer.
package rdback_ser_pkg;

  localparam int NUM_SLOTS = 2;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  function automatic int beats_of(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

endpackage

// File: rtl/rdback_line_buf.sv
// Two-slot ping-pong line store. The next-cycle view of the read slot is
// exported so the output stage can register beats without an extra bubble.
module rdback_line_buf
  import rdback_ser_pkg::*;
#(
  parameter int IN_WIDTH = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cap,
  input  logic [IN_WIDTH-1:0] cap_data,
  input  logic                pop,
  output logic [1:0]          occ,
  output logic                rd_valid_nxt,
  output logic [IN_WIDTH-1:0] rd_line_nxt
);

  logic [NUM_SLOTS-1:0][IN_WIDTH-1:0] mem;
  logic [NUM_SLOTS-1:0]               vld, vld_nxt;
  logic                               wp, rp, rp_nxt;

  assign occ    = {1'b0, vld[0]} + {1'b0, vld[1]};
  assign rp_nxt = rp ^ pop;

  always_comb begin
    vld_nxt = vld;
    if (pop) vld_nxt[rp] = 1'b0;
    if (cap) vld_nxt[wp] = 1'b1;
  end

  // A capture landing in the slot that becomes current must bypass mem.
  assign rd_valid_nxt = vld_nxt[rp_nxt];
  assign rd_line_nxt  = (cap && (wp == rp_nxt)) ? cap_data : mem[rp_nxt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      wp  <= 1'b0;
      rp  <= 1'b0;
    end else begin
      vld <= vld_nxt;
      rp  <= rp_nxt;
      if (cap) wp <= ~wp;
    end
  end

  // Payload needs no reset; validity is tracked by vld.
  always_ff @(posedge clk) begin
    if (cap) mem[wp] <= cap_data;
  end

endmodule

// File: rtl/rdback_serializer.sv
// Drains 512-bit read-back lines from a standard FIFO and emits them as a
// registered valid/ready beat stream, LSB beat first, with a line counter.
module rdback_serializer
  import rdback_ser_pkg::*;
#(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdback_fifo_empty,
  output logic                 rdback_fifo_rden,
  input  logic [IN_WIDTH-1:0]  rdback_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic [CNT_WIDTH-1:0] lines_sent
);

  localparam int BEATS = beats_of(IN_WIDTH, OUT_WIDTH);
  localparam int BI_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e                         state, state_nxt;
  logic [BI_W-1:0]                bi, bi_nxt;
  logic                           rden_d, inflight, hs, last, pop;
  logic [1:0]                     occ;
  logic [2:0]                     owned;
  logic                           rd_valid_nxt;
  logic [IN_WIDTH-1:0]            rd_line_nxt;
  logic [BEATS-1:0][OUT_WIDTH-1:0] line_beats;
  logic [OUT_WIDTH-1:0]           m_data_nxt;
  logic                           m_last_nxt;

  // Owned lines = buffered + pending; the strobe term keeps it at most two.
  assign inflight         = rden_d;
  assign owned            = 3'(occ) + 3'(inflight) + 3'(rden_d);
  assign rdback_fifo_rden = rst_n & ~rdback_fifo_empty & (owned < 3'(NUM_SLOTS));

  assign hs         = (state == SEND) & m_ready;
  assign last       = (bi == BI_W'(BEATS - 1));
  assign pop        = hs & last;
  assign line_beats = rd_line_nxt;

  rdback_line_buf #(.IN_WIDTH(IN_WIDTH)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .cap          (rden_d),
    .cap_data     (rdback_data),
    .pop          (pop),
    .occ          (occ),
    .rd_valid_nxt (rd_valid_nxt),
    .rd_line_nxt  (rd_line_nxt)
  );

  always_comb begin
    state_nxt = state;
    bi_nxt    = bi;
    case (state)
      IDLE: if (rd_valid_nxt) begin
        state_nxt = SEND;
        bi_nxt    = '0;
      end
      SEND: begin
        if (pop) begin
          bi_nxt    = '0;
          state_nxt = rd_valid_nxt ? SEND : IDLE;
        end else if (hs) begin
          bi_nxt = bi + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Beat registers are loaded from next-cycle state so they stay put while stalled.
    m_data_nxt = (state_nxt == SEND) ? line_beats[bi_nxt] : '0;
    m_last_nxt = (state_nxt == SEND) && (bi_nxt == BI_W'(BEATS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bi         <= '0;
      rden_d     <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      lines_sent <= '0;
    end else begin
      state      <= state_nxt;
      bi         <= bi_nxt;
      rden_d     <= rdback_fifo_rden;
      m_valid    <= (state_nxt == SEND);
      m_data     <= m_data_nxt;
      m_last     <= m_last_nxt;
      lines_sent <= lines_sent + CNT_WIDTH'(pop);
    end
  end

endmodule

// File: tb/tb_rdback_serializer.sv
// Scoreboard bench: FIFO model pushes expected beats on each read, a negedge
// monitor pops and compares every beat the DUT presents.
module tb_rdback_serializer;

  localparam int IN_W  = 512;
  localparam int OUT_W = 64;
  localparam int CW    = 4;
  localparam int NB    = IN_W / OUT_W;

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic             l;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rdback_fifo_empty = 1'b1;
  logic              rdback_fifo_rden;
  logic [IN_W-1:0]   rdback_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [OUT_W-1:0]  m_data;
  logic              m_last;
  logic [CW-1:0]     lines_sent;

  logic [IN_W-1:0]   fifo_q[$];
  beat_t             exp_q[$];
  int                rden_hist[$];
  int                beat_cyc[$];
  int                last_cyc[$];
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                rd_lines = 0;
  int                done_lines = 0;
  logic              hold_empty = 1'b0;
  logic              rnd_ready = 1'b0;
  logic              stall = 1'b0;
  logic [OUT_W-1:0]  st_data = '0;
  logic              st_last = 1'b0;
  logic [IN_W-1:0]   pop_ln;

  rdback_serializer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rdback_fifo_empty (rdback_fifo_empty),
    .rdback_fifo_rden  (rdback_fifo_rden),
    .rdback_data       (rdback_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_data            (m_data),
    .m_last            (m_last),
    .lines_sent        (lines_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Standard FIFO model: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      rd_lines = 0;
    end else if (rdback_fifo_rden && fifo_q.size() > 0) begin
      pop_ln = fifo_q.pop_front();
      rdback_data <= pop_ln;
      rd_lines = rd_lines + 1;
      for (int k = 0; k < NB; k++)
        exp_q.push_back('{d: pop_ln[k*OUT_W +: OUT_W], l: (k == NB - 1)});
    end
  end

  always @(posedge clk) begin
    #2;
    rdback_fifo_empty = (fifo_q.size() == 0) || hold_empty;
  end

  always @(posedge clk) begin
    #1;
    m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      done_lines = 0;
      stall      = 1'b0;
    end else begin
      if (rdback_fifo_rden) begin
        rden_hist.push_back(cyc);
        checks++;
        if (rdback_fifo_empty) begin
          errors++;
          $display("FAIL rden_empty: rden=1 while empty at cycle %0d", cyc);
        end
        checks++;
        if (rd_lines - done_lines > 1) begin
          errors++;
          $display("FAIL rden_owned: %0d lines owned at strobe, need <=1", rd_lines - done_lines);
        end
      end
      if (stall) begin
        checks++;
        if (!m_valid || m_data !== st_data || m_last !== st_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h/%0b, want v=1 %h/%0b", m_valid, m_data, m_last, st_data, st_last);
        end
      end
      if (m_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra: got %h/%0b, want no beat", m_data, m_last);
        end else if (m_data !== exp_q[0].d || m_last !== exp_q[0].l) begin
          errors++;
          $display("FAIL beat: got %h/%0b, want %h/%0b", m_data, m_last, exp_q[0].d, exp_q[0].l);
        end
        if (m_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          beat_cyc.push_back(cyc);
          if (m_last) begin
            done_lines = done_lines + 1;
            last_cyc.push_back(cyc);
          end
          stall = 1'b0;
        end else begin
          stall   = 1'b1;
          st_data = m_data;
          st_last = m_last;
        end
      end else begin
        stall = 1'b0;
      end
    end
  end

  function automatic logic [IN_W-1:0] mk_line(input int tag);
    logic [IN_W-1:0] l;
    for (int k = 0; k < NB; k++)
      l[k*OUT_W +: OUT_W] = (tag == 0) ? 64'(k + 1) : {16'(tag), 40'h00A5A5A500, 8'(k + 1)};
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic wait_lines(input int n, input string nm);
    int c;
    c = 0;
    while (done_lines < n && c < 2000) begin
      step();
      c++;
    end
    chk({nm, "_done"}, done_lines, n);
  endtask

  initial begin
    int rb, bb, lb, cnt, c;

    // reset state
    repeat (3) step();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rden", rdback_fifo_rden, 0);
    chk("rst_lines", lines_sent, 0);
    #2 rst_n = 1'b1;
    step();

    // single line: latency and beat timing
    rb = rden_hist.size(); bb = beat_cyc.size();
    fifo_q.push_back(mk_line(0));
    wait_lines(1, "t1");
    if (rden_hist.size() > rb && beat_cyc.size() >= bb + NB) begin
      chk("t1_first_beat_lat", beat_cyc[bb] - rden_hist[rb], 2);
      chk("t1_line_span", beat_cyc[bb+NB-1] - beat_cyc[bb], NB - 1);
    end
    step();
    chk("t1_lines", lines_sent, 1);

    // five back-to-back lines
    rb = rden_hist.size(); bb = beat_cyc.size(); lb = last_cyc.size();
    for (int i = 1; i <= 5; i++) fifo_q.push_back(mk_line(i));
    wait_lines(6, "t2");
    if (beat_cyc.size() >= bb + 5*NB && last_cyc.size() > lb) begin
      chk("t2_no_gap", beat_cyc[bb+5*NB-1] - beat_cyc[bb], 5*NB - 1);
      cnt = 0;
      for (int i = rb; i < rden_hist.size(); i++)
        if (rden_hist[i] <= last_cyc[lb]) cnt++;
      chk("t2_rden_before_last", cnt, 2);
    end
    step();
    chk("t2_lines", lines_sent, 6);

    // random back-pressure
    rnd_ready = 1'b1;
    for (int i = 6; i <= 8; i++) fifo_q.push_back(mk_line(i));
    wait_lines(9, "t3");
    rnd_ready = 1'b0;
    repeat (2) step();
    chk("t3_lines", lines_sent, 9);

    // FIFO empty between lines
    hold_empty = 1'b1;
    for (int i = 9; i <= 11; i++) fifo_q.push_back(mk_line(i));
    for (int i = 0; i < 3; i++) begin
      hold_empty = 1'b0;
      step();
      hold_empty = 1'b1;
      wait_lines(10 + i, "t4");
      repeat (3) step();
      chk("t4_idle_valid", m_valid, 0);
    end
    hold_empty = 1'b0;
    chk("t4_lines", lines_sent, 12);

    // reset mid-line at beat 4
    bb = beat_cyc.size();
    for (int i = 20; i <= 22; i++) fifo_q.push_back(mk_line(i));
    c = 0;
    while (beat_cyc.size() < bb + 4 && c < 500) begin
      step();
      c++;
    end
    chk("t5_reach_beat4", beat_cyc.size() - bb, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_m_valid", m_valid, 0);
    chk("t5_m_last", m_last, 0);
    chk("t5_m_data", m_data, 0);
    chk("t5_rden", rdback_fifo_rden, 0);
    chk("t5_lines", lines_sent, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    wait_lines(1, "t5_restart");
    step();
    chk("t5_lines_after", lines_sent, 1);

    // counter wrap with 4-bit count
    repeat (3) step();
    rst_n = 1'b0;
    step();
    #2 rst_n = 1'b1;
    chk("t6_lines_clear", lines_sent, 0);
    for (int i = 30; i < 47; i++) fifo_q.push_back(mk_line(i));
    wait_lines(17, "t6");
    step();
    chk("t6_wrap", lines_sent, 1);

    repeat (4) step();
    chk("end_exp_empty", exp_q.size(), 0);
    chk("end_fifo_empty", fifo_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
